alu_seq: RTL
============

Name: alu_seq

Overview:
Parameterised, handshaked successor to the team's 8-bit combinational ALU.
- Operand width is set by WIDTH.
- Results and a full flag set (carry, zero, negative, overflow) are registered.
- MUL and DIV are computed iteratively over several cycles.
- Sits between an operand-issue stage and a result consumer; valid/ready on both sides, one operation in flight.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 4..32)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept an operation
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  4  operation select (alu_op_e)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  result
out_carry  output  1  carry/borrow/shift-out/high-half/div-by-zero flag
out_zero  output  1  out_result == 0
out_neg  output  1  out_result[WIDTH-1]
out_ovf  output  1  signed overflow (ADD/SUB only, else 0)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n).
  - While rst_n is low: state=IDLE, out_valid=0, out_result=0, all flags=0.
  - in_ready=1 from the first edge after release.
- Opcodes (all unsigned unless noted):
  - 0 ADD; 1 SUB (A-B)
  - 2 MUL (low WIDTH bits); 3 DIV (quotient A/B)
  - 4 SHL1; 5 SHR1 (logical); 6 ROL1; 7 ROR1
  - 8 AND; 9 OR; 10 XOR; 11 NOR; 12 NAND; 13 XNOR
  - 14 GT (result 1 if A>B, else 0); 15 EQ (result 1 if A==B, else 0)
- Carry flag:
  - ADD: carry out.
  - SUB: borrow (1 when A<B).
  - MUL: 1 if upper WIDTH bits of the 2*WIDTH product are nonzero.
  - SHL/ROL: bit A[WIDTH-1]. SHR/ROR: bit A[0].
  - DIV: 1 on B==0.
  - Logic and compare ops: 0.
- Overflow flag: signed two's-complement overflow for ADD/SUB; 0 otherwise.
- DIV by zero: out_result = all ones, out_carry=1, no hang; latency unchanged.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, latch A, B and op.
    - Single-cycle op: compute, go to DONE; out_valid=1 one cycle after the accept edge.
    - MUL/DIV: go to BUSY, counter=WIDTH.
  - BUSY: one shift-add (MUL) or one restoring-divide step (DIV) per cycle; counter decrements. At 0, register result and flags, go to DONE.
    - out_valid rises exactly WIDTH+1 edges after the accept edge.
  - DONE: out_valid=1; result and flags held stable. On out_ready, go to IDLE with out_valid=0.
- Handshake and throughput:
  - in_ready=0 in BUSY and DONE, so inputs are ignored there; in_a/in_b/in_op may change freely after accept.
  - Maximum throughput is one op per 2 cycles.
- out_ready may be held high in advance; the result is then consumed on the first DONE cycle.
- Zero and negative flags are derived from the registered result, so they are consistent with out_result in every op.
- Reset asserted mid-BUSY or mid-DONE aborts the operation; there is no output glitch after release.

Decomposition:
- Package alu_pkg:
  - alu_op_e (4-bit enum, encodings above).
  - alu_state_e (IDLE/BUSY/DONE).
  - Flag struct alu_flags_t {carry, zero, neg, ovf}.
- One sub-module, alu_muldiv_iter:
  - Iterative multiply/restoring divide datapath.
  - Interface: start, is_div, a, b, busy, done, result, hi_nonzero, div_by_zero.
- Single-cycle ops stay combinational inside alu_seq.

Test Plan:
- WIDTH=8, ADD A=0x0A B=0x02 -> result 0x0C, carry=0, zero=0, out_valid 1 cycle after accept.
- SUB A=0x02 B=0x0A -> 0xF8, carry=1, neg=1. ADD 0x7F+0x01 -> 0x80, ovf=1, neg=1.
- MUL 0x10*0x11 -> result 0x10, carry=1; out_valid exactly 9 cycles after accept; in_ready=0 throughout.
- DIV 0xF6/0x0A -> 0x18, carry=0. DIV 0x55/0x00 -> 0xFF, carry=1, same 9-cycle latency.
- Sweep all 16 opcodes with A=0x0A, B=0x02 (ROL -> 0x14, ROR -> 0x05, GT -> 0x01, EQ -> 0x00).
  - Hold out_ready=0 for 5 cycles -> result and flags stable, in_ready=0, new in_valid ignored.
- Assert rst_n low at BUSY cycle 4 of a MUL -> out_valid=0, result=0 immediately; after release in_ready=1 and a following ADD completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU.
// Opcodes, FSM states and the registered flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EQ   = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;

  function automatic logic is_iter(alu_op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider.
// One step per cycle; done is high for the cycle after the last step.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             hi_nonzero,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_div;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_b;

  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_sum;

  // remainder always stays below the divisor, so WIDTH bits suffice
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_b};
  assign w_sum   = r_prod + (r_mplr[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_div   <= 1'b0;
      r_prod  <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_b     <= '0;
    end else if (start) begin
      r_cnt   <= CW'(WIDTH);
      r_busy  <= 1'b1;
      r_div   <= is_div;
      r_prod  <= '0;
      r_mcand <= {{WIDTH{1'b0}}, a};
      r_mplr  <= b;
      r_quo   <= a;
      r_rem   <= '0;
      r_b     <= b;
    end else if (r_busy) begin
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CW'(1);
        if (r_div) begin
          if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
        end else begin
          r_prod  <= w_sum;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
        end
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_busy && (r_cnt == '0);
  assign result      = r_div ? r_quo : r_prod[WIDTH-1:0];
  assign hi_nonzero  = |r_prod[2*WIDTH-1:WIDTH];
  assign div_by_zero = (r_b == '0);

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result and flags.
// Single-cycle ops are computed at accept; MUL/DIV go to the iterator.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
);

  localparam int MSB = WIDTH - 1;

  alu_state_e r_state;
  alu_state_e w_next;
  alu_op_e    r_op;
  alu_op_e    w_op;
  alu_flags_t r_flags;
  logic       r_rst_done;

  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic             w_c;
  logic             w_v;
  logic             w_accept;
  logic             w_iter;
  logic             w_start;

  logic             w_md_busy;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_res;
  logic             w_md_hinz;
  logic             w_md_dbz;

  assign w_op     = alu_op_e'(in_op);
  assign w_iter   = is_iter(w_op);
  assign in_ready = (r_state == IDLE) && r_rst_done;
  assign w_accept = in_valid && in_ready;
  assign w_add    = {1'b0, in_a} + {1'b0, in_b};
  assign w_sub    = {1'b0, in_a} - {1'b0, in_b};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    unique case (w_op)
      OP_ADD: begin
        w_res = w_add[MSB:0];
        w_c   = w_add[WIDTH];
        w_v   = (in_a[MSB] == in_b[MSB]) &&
                (w_add[MSB] != in_a[MSB]);
      end
      OP_SUB: begin
        w_res = w_sub[MSB:0];
        w_c   = w_sub[WIDTH];
        w_v   = (in_a[MSB] != in_b[MSB]) &&
                (w_sub[MSB] != in_a[MSB]);
      end
      OP_MUL, OP_DIV: ;
      OP_SHL: begin
        w_res = {in_a[MSB-1:0], 1'b0};
        w_c   = in_a[MSB];
      end
      OP_SHR: begin
        w_res = {1'b0, in_a[MSB:1]};
        w_c   = in_a[0];
      end
      OP_ROL: begin
        w_res = {in_a[MSB-1:0], in_a[MSB]};
        w_c   = in_a[MSB];
      end
      OP_ROR: begin
        w_res = {in_a[0], in_a[MSB:1]};
        w_c   = in_a[0];
      end
      OP_AND:  w_res = in_a & in_b;
      OP_OR:   w_res = in_a | in_b;
      OP_XOR:  w_res = in_a ^ in_b;
      OP_NOR:  w_res = ~(in_a | in_b);
      OP_NAND: w_res = ~(in_a & in_b);
      OP_XNOR: w_res = ~(in_a ^ in_b);
      OP_GT:   w_res = WIDTH'(in_a > in_b);
      OP_EQ:   w_res = WIDTH'(in_a == in_b);
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next  = w_iter ? BUSY : DONE;
          w_start = w_iter;
        end
      end
      BUSY: begin
        if (w_md_done)      w_next = DONE;
        else if (!w_md_busy) w_next = IDLE;
      end
      DONE: begin
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rst_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_ADD;
      r_result <= '0;
      r_flags  <= '0;
    end else if ((r_state == IDLE) && w_accept) begin
      r_op <= w_op;
      if (!w_iter) begin
        r_result <= w_res;
        r_flags  <= '{carry: w_c, zero: ~|w_res,
                      neg: w_res[MSB], ovf: w_v};
      end
    end else if ((r_state == BUSY) && w_md_done) begin
      r_result <= w_md_res;
      r_flags  <= '{carry: (r_op == OP_DIV) ? w_md_dbz : w_md_hinz,
                    zero: ~|w_md_res,
                    neg: w_md_res[MSB], ovf: 1'b0};
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (w_start),
    .is_div      (w_op == OP_DIV),
    .a           (in_a),
    .b           (in_b),
    .busy        (w_md_busy),
    .done        (w_md_done),
    .result      (w_md_res),
    .hi_nonzero  (w_md_hinz),
    .div_by_zero (w_md_dbz)
  );

  assign out_valid  = (r_state == DONE);
  assign out_result = r_result;
  assign out_carry  = r_flags.carry;
  assign out_zero   = r_flags.zero;
  assign out_neg    = r_flags.neg;
  assign out_ovf    = r_flags.ovf;

endmodule
